// File: rtl/fsm_seq_ctrl_pkg.sv
// Shared types for the handshake sequencer: sequencer state encodings and the
// target FSM phase names used by anything that models or observes the target.
package fsm_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI1  = 3'd1,
        ST_LO1  = 3'd2,
        ST_HI2  = 3'd3,
        ST_LO2  = 3'd4,
        ST_FIN  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // Phases of the Idle/Start/Stop/Clear target the sequencer drives.
    typedef enum logic [1:0] {
        TGT_IDLE  = 2'd0,
        TGT_START = 2'd1,
        TGT_STOP  = 2'd2,
        TGT_CLEAR = 2'd3
    } tgt_phase_t;

    function automatic logic is_drive_hi(input state_t s);
        return (s == ST_HI1) || (s == ST_HI2);
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_HI1) || (s == ST_LO1) || (s == ST_HI2) || (s == ST_LO2);
    endfunction

endpackage

// File: rtl/fsm_seq_ctrl_phase_timer.sv
// Loadable down-counter that times one sequencer phase; expire flags the
// last cycle of the phase.
module phase_timer #(
    parameter int DW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] val,
    output logic          expire
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            val <= '0;
        else if (load)
            val <= load_val;
        else if (val != '0)
            val <= val - DW'(1);
    end

    assign expire = (val == '0);

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Drives the A input of a four-phase handshake FSM through ncyc full cycles
// with a programmable per-phase dwell, checking the K2/K1 acknowledge pulses.
module fsm_seq_ctrl
    import fsm_seq_ctrl_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    input  logic [DW-1:0] dwell,
    input  logic [CW-1:0] ncyc,
    input  logic          K1,
    input  logic          K2,
    output logic          A,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cyc_cnt
);

    state_t        state, state_nxt;
    logic          load, accept, cnt_inc;
    logic          first_q;
    logic [DW-1:0] dm1_q, dwell_m1, load_val, tmr_val;
    logic [CW-1:0] ncyc_q, cyc_cnt_p1;
    logic          expire, exp_k1, exp_k2, ack_bad;

    // A dwell of 0 behaves as 1, so the timer reload is max(dwell,1)-1.
    assign dwell_m1   = (dwell == '0) ? '0 : dwell - DW'(1);
    assign load_val   = accept ? dwell_m1 : dm1_q;
    assign cyc_cnt_p1 = cyc_cnt + CW'(1);

    phase_timer #(.DW(DW)) u_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (load),
        .load_val (load_val),
        .val      (tmr_val),
        .expire   (expire)
    );

    // Each ack is expected only in the first cycle of its phase and must be
    // low in every other busy cycle.
    assign exp_k2  = (state == ST_HI2) && first_q;
    assign exp_k1  = (state == ST_LO2) && first_q;
    assign ack_bad = is_busy(state) && ((K2 != exp_k2) || (K1 != exp_k1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    accept = 1'b1;
                    if (ncyc != '0) begin
                        state_nxt = ST_HI1;
                        load      = 1'b1;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_HI1, ST_LO1, ST_HI2: begin
                if (ack_bad) begin
                    state_nxt = ST_ERR;
                end else if (expire) begin
                    load = 1'b1;
                    if (state == ST_HI1)      state_nxt = ST_LO1;
                    else if (state == ST_LO1) state_nxt = ST_HI2;
                    else                      state_nxt = ST_LO2;
                end
            end
            ST_LO2: begin
                if (ack_bad) begin
                    state_nxt = ST_ERR;
                end else if (expire) begin
                    cnt_inc = 1'b1;
                    if (cyc_cnt_p1 == ncyc_q) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_HI1;
                        load      = 1'b1;
                    end
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            A       <= 1'b0;
            first_q <= 1'b0;
            dm1_q   <= '0;
            ncyc_q  <= '0;
            cyc_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            A       <= is_drive_hi(state_nxt);
            first_q <= load;
            if (accept) begin
                dm1_q   <= dwell_m1;
                ncyc_q  <= ncyc;
                cyc_cnt <= '0;
                err     <= 1'b0;
            end else begin
                if (cnt_inc)
                    cyc_cnt <= cyc_cnt_p1;
                if (state_nxt == ST_ERR)
                    err <= 1'b1;
            end
        end
    end

    assign busy = is_busy(state);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl with a behavioural Idle/Start/Stop/Clear
// target producing the K2/K1 acknowledge pulses from A.
module tb_fsm_seq_ctrl;
    import fsm_seq_ctrl_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] dwell;
    logic [3:0] ncyc;
    logic       K1, K2, A, busy, done, err;
    logic [3:0] cyc_cnt;

    logic       tgt_rst, k1_inj, tgt_r;
    tgt_phase_t tgt;

    int tot = 0;
    int bad = 0;

    always #5 Clock = ~Clock;

    fsm_seq_ctrl #(.DW(8), .CW(4)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (start),
        .dwell   (dwell),
        .ncyc    (ncyc),
        .K1      (K1),
        .K2      (K2),
        .A       (A),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .cyc_cnt (cyc_cnt)
    );

    // Target FSM: K2 on Stop->Clear, K1 on Clear->Idle (Mealy outputs).
    assign tgt_r = tgt_rst | Reset;
    always @(posedge Clock or posedge tgt_r) begin
        if (tgt_r) tgt <= TGT_IDLE;
        else case (tgt)
            TGT_IDLE:  if (A)  tgt <= TGT_START;
            TGT_START: if (!A) tgt <= TGT_STOP;
            TGT_STOP:  if (A)  tgt <= TGT_CLEAR;
            default:   if (!A) tgt <= TGT_IDLE;
        endcase
    end
    assign K2 = (tgt == TGT_STOP) && A && !tgt_r;
    assign K1 = ((tgt == TGT_CLEAR) && !A && !tgt_r) || k1_inj;

    typedef struct {
        int dw;
        int nc;
        int lat;
        int cnt;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input int tag, input int cyc,
                       input int act, input int exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t%0d c%0d got=%0d want=%0d", name, tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Start a run and check A/busy/done/err every cycle against the ideal
    // waveform, then the final cycle count.
    task automatic run_vec(input int tag, input int dw, input int nc,
                           input int lat, input int cnt);
        int d, span;
        logic ea;
        d    = (dw == 0) ? 1 : dw;
        span = 4 * d * nc;
        dwell = 8'(dw);
        ncyc  = 4'(nc);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            ea = (c <= span) && ((((c - 1) / d) % 4) == 0 || (((c - 1) / d) % 4) == 2);
            chk("a",    tag, c, int'(A),    int'(ea));
            chk("busy", tag, c, int'(busy), int'(c <= span));
            chk("done", tag, c, int'(done), int'(c == lat));
            chk("err",  tag, c, int'(err),  0);
            if (c <= lat) step();
        end
        chk("cyc_cnt", tag, lat + 1, int'(cyc_cnt), cnt);
    endtask

    initial begin
        tbl[0] = '{2, 1, 9, 1};
        tbl[1] = '{0, 3, 13, 3};
        tbl[2] = '{1, 2, 9, 2};
        tbl[3] = '{3, 2, 25, 2};
        tbl[4] = '{0, 0, 1, 0};

        Reset = 1'b1; tgt_rst = 1'b0; k1_inj = 1'b0;
        start = 1'b0; dwell = '0; ncyc = '0;
        step(); step();
        chk("rst_a",    0, 0, int'(A),       0);
        chk("rst_busy", 0, 0, int'(busy),    0);
        chk("rst_done", 0, 0, int'(done),    0);
        chk("rst_err",  0, 0, int'(err),     0);
        chk("rst_cnt",  0, 0, int'(cyc_cnt), 0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(i, tbl[i].dw, tbl[i].nc, tbl[i].lat, tbl[i].cnt);
            step();
        end

        // Target held in reset: K2 missing in first HI2 cycle (cycle 3).
        tgt_rst = 1'b1;
        dwell = 8'd1; ncyc = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("noack_err",  10, 4, int'(err),     1);
        chk("noack_a",    10, 4, int'(A),       0);
        chk("noack_busy", 10, 4, int'(busy),    0);
        chk("noack_cnt",  10, 4, int'(cyc_cnt), 0);
        for (int c = 4; c < 8; c++) begin
            chk("noack_done", 10, c, int'(done), 0);
            chk("noack_hold", 10, c, int'(err),  1);
            step();
        end
        tgt_rst = 1'b0;
        step();
        run_vec(11, 2, 1, 9, 1);
        step();

        // Reset during HI2 of a dwell=4 run; a start pulse mid-run is ignored.
        dwell = 8'd4; ncyc = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) begin start = 1'b1; dwell = 8'd1; ncyc = 4'd1; end
            if (c == 4) start = 1'b0;
            chk("mid_a",    12, c, int'(A),    int'(c <= 4 || c >= 9));
            chk("mid_busy", 12, c, int'(busy), 1);
            if (c < 10) step();
        end
        #3 Reset = 1'b1;
        #1;
        chk("arst_a",    12, 10, int'(A),       0);
        chk("arst_busy", 12, 10, int'(busy),    0);
        chk("arst_done", 12, 10, int'(done),    0);
        chk("arst_err",  12, 10, int'(err),     0);
        chk("arst_cnt",  12, 10, int'(cyc_cnt), 0);
        step();
        Reset = 1'b0;
        step();

        // Spurious K1 in HI1 of the second cycle (cycle 5) with dwell=0, ncyc=3.
        dwell = 8'd0; ncyc = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            chk("spk_a", 13, c, int'(A), int'(c == 1 || c == 3));
            step();
        end
        k1_inj = 1'b1;
        step();
        k1_inj = 1'b0;
        chk("spk_err",  13, 6, int'(err),     1);
        chk("spk_cnt",  13, 6, int'(cyc_cnt), 1);
        chk("spk_busy", 13, 6, int'(busy),    0);
        chk("spk_a",    13, 6, int'(A),       0);
        for (int c = 7; c < 10; c++) begin
            step();
            chk("spk_hold", 13, c, int'(err), 1);
        end
        tgt_rst = 1'b1;
        step();
        tgt_rst = 1'b0;
        run_vec(14, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
